// File: rtl/ext_sram_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ext_sram_if                                                           |
// | Multiplexed 16-bit external SRAM bus (address/data + strobes).        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface ext_sram_if;
    logic [15:0] ad_in;
    logic [15:0] ad_out;
    logic        ad_oe;
    logic        ale0;
    logic        ale1;
    logic        oe;
    logic        we;
    logic        bhe_n;

    modport master (
        output ad_in, ale0, ale1, oe, we, bhe_n,
        input  ad_out, ad_oe
    );

    modport slave (
        input  ad_in, ale0, ale1, oe, we, bhe_n,
        output ad_out, ad_oe
    );
endinterface
`default_nettype wire

// File: rtl/ext_sram_target.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ext_sram_target                                                       |
// | Bus responder for the multiplexed external SRAM bus, serving a        |
// | word-wide on-chip memory window through a synchronous memory port.    |
// | Optional write protection: define EXT_SRAM_TARGET_WPROT_EN.           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module ext_sram_target #(
    parameter logic [31:0] BASE = 32'h0001_0000,
    parameter int          AW   = 12,
    parameter int          TMO  = 15
) (
    input  wire logic          clk,
    input  wire logic          reset,
    ext_sram_if.slave          bus,
    output logic [AW-1:0]      mem_addr,
    output logic               mem_re,
    input  wire logic [15:0]   mem_rdata,
    output logic               mem_we,
    output logic [1:0]         mem_be,
    output logic [15:0]        mem_wdata,
    output logic               busy,
    output logic               err_tmo
`ifdef EXT_SRAM_TARGET_WPROT_EN
    ,
    input  wire logic          wp,
    output logic               wp_viol
`endif
);

    localparam int             CW       = $clog2(TMO + 1);
    localparam logic [CW-1:0]  TMO_LAST = CW'(TMO - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] A0   = 3'd1;
    localparam logic [2:0] A1   = 3'd2;
    localparam logic [2:0] RD   = 3'd3;
    localparam logic [2:0] WR   = 3'd4;
    localparam logic [2:0] MISS = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [15:0]   lat_lo;
    logic          ble_n;
    logic          drive_en;
    logic          ale0_q;
    logic          ale1_q;
    logic          we_q;

    logic          ale0_fall;
    logic          ale1_fall;
    logic          we_fall;
    logic          tmo_hit;
    logic [30:0]   word;
    logic          hit;
    logic [1:0]    be_new;
    logic          wr_block;

    assign ale0_fall = ale0_q & ~bus.ale0;
    assign ale1_fall = ale1_q & ~bus.ale1;
    assign we_fall   = we_q & ~bus.we;
    // Fires on the edge that completes the TMO-th cycle spent in the phase.
    assign tmo_hit   = (cnt == TMO_LAST);

    // Word address assembled from the live high phase and the latched low phase.
    assign word   = {bus.ad_in[14:0], lat_lo};
    assign hit    = (word[30:AW] == BASE[31:AW+1]);
    assign be_new = {~bus.bhe_n, ~ble_n};

`ifdef EXT_SRAM_TARGET_WPROT_EN
    assign wr_block = wp;
`else
    assign wr_block = 1'b0;
`endif

    assign busy       = (state != IDLE);
    assign bus.ad_oe  = drive_en;
    assign bus.ad_out = drive_en ? mem_rdata : 16'h0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_lo    <= 16'h0000;
            ble_n     <= 1'b0;
            drive_en  <= 1'b0;
            ale0_q    <= 1'b0;
            ale1_q    <= 1'b0;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 2'b00;
            mem_wdata <= 16'h0000;
            err_tmo   <= 1'b0;
`ifdef EXT_SRAM_TARGET_WPROT_EN
            wp_viol   <= 1'b0;
`endif
        end else begin
            ale0_q  <= bus.ale0;
            ale1_q  <= bus.ale1;
            we_q    <= bus.we;
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
            err_tmo <= 1'b0;
`ifdef EXT_SRAM_TARGET_WPROT_EN
            wp_viol <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.ale0) begin
                        state <= A0;
                        cnt   <= '0;
                    end
                end
                A0: begin
                    if (ale0_fall) begin
                        lat_lo <= bus.ad_in;
                        state  <= A1;
                        cnt    <= '0;
                    end else if (tmo_hit) begin
                        err_tmo <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                A1: begin
                    if (ale1_fall) begin
                        ble_n    <= bus.ad_in[15];
                        mem_addr <= word[AW-1:0];
                        if (hit && bus.oe) begin
                            state    <= RD;
                            mem_re   <= 1'b1;
                            drive_en <= 1'b1;
                        end else if (hit && bus.we) begin
                            state <= WR;
                        end else begin
                            state <= MISS;
                        end
                    end else if (tmo_hit) begin
                        err_tmo <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RD: begin
                    if (!bus.oe) begin
                        drive_en <= 1'b0;
                        state    <= bus.ale0 ? A0 : IDLE;
                        cnt      <= '0;
                    end
                end
                WR: begin
                    if (we_fall) begin
                        mem_wdata <= bus.ad_in;
                        mem_be    <= be_new;
                        mem_we    <= (|be_new) & ~wr_block;
`ifdef EXT_SRAM_TARGET_WPROT_EN
                        wp_viol   <= wp;
`endif
                        state     <= bus.ale0 ? A0 : IDLE;
                        cnt       <= '0;
                    end
                end
                MISS: begin
                    if (!bus.oe && !bus.we) begin
                        state <= bus.ale0 ? A0 : IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ext_sram_target.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ext_sram_target                                                    |
// | Directed, table-driven bench for ext_sram_target.                     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_ext_sram_target;

    logic        clk;
    logic        reset;
    logic [11:0] mem_addr;
    logic        mem_re;
    logic [15:0] rdata;
    logic        mem_we;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        err_tmo;
`ifdef EXT_SRAM_TARGET_WPROT_EN
    logic        wp;
    logic        wp_viol;
    int          wpv_cnt = 0;
`endif

    ext_sram_if bus_if ();

    ext_sram_target #(
        .BASE (32'h0001_0000),
        .AW   (12),
        .TMO  (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (rdata),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .err_tmo   (err_tmo)
`ifdef EXT_SRAM_TARGET_WPROT_EN
        ,
        .wp        (wp),
        .wp_viol   (wp_viol)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:4095];

    int          re_cnt  = 0;
    int          we_cnt  = 0;
    int          err_cnt = 0;
    int          oe_cyc  = 0;
    logic [11:0] re_addr = '0;
    logic [11:0] we_addr = '0;
    logic [15:0] we_data = '0;
    logic [1:0]  we_be   = '0;

    // Memory model (one-cycle read latency) and event recorder.
    always @(posedge clk) begin
        if (mem_re) begin
            rdata   <= mem[mem_addr];
            re_cnt  <= re_cnt + 1;
            re_addr <= mem_addr;
        end
        if (mem_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= mem_addr;
            we_data <= mem_wdata;
            we_be   <= mem_be;
        end
        if (err_tmo)      err_cnt <= err_cnt + 1;
        if (bus_if.ad_oe) oe_cyc  <= oe_cyc + 1;
`ifdef EXT_SRAM_TARGET_WPROT_EN
        if (wp_viol)      wpv_cnt <= wpv_cnt + 1;
`endif
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus_if.ad_in = 16'h0000;
        bus_if.ale0  = 1'b0;
        bus_if.ale1  = 1'b0;
        bus_if.oe    = 1'b0;
        bus_if.we    = 1'b0;
        bus_if.bhe_n = 1'b1;
    endtask

    // Drives ALE0 phase, its release, and the ALE1 phase (three cycles).
    task automatic addr_phases(input logic [31:0] addr, input logic ble_n);
        @(negedge clk);
        bus_if.ale0  = 1'b1;
        bus_if.ad_in = addr[16:1];
        @(negedge clk);
        bus_if.ale0  = 1'b0;
        @(negedge clk);
        bus_if.ale1  = 1'b1;
        bus_if.ad_in = {ble_n, addr[31:17]};
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        ble_n;
        logic        bhe_n;
        logic        rd;
        logic        wr;
        logic [15:0] wdata;
        logic        exp_re;
        logic        exp_we;
        logic [11:0] exp_addr;
        logic [1:0]  exp_be;
        logic [15:0] exp_out;
        logic        exp_oe;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          re0, we0, err0, oe0, first_err;
        logic        t3_oe;
        logic [15:0] t3_out;
        logic        busy16;

        for (int i = 0; i < 4096; i++) mem[i] = 16'hA000 ^ 16'(i);
        mem[2] = 16'hBEEF;

        //            addr          bln   bhn   rd    wr    wdata     re    we    maddr    be     out       oe
        vecs[0]  = '{32'h0001_0004, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 12'h002, 2'b00, 16'hBEEF, 1'b1};
        vecs[1]  = '{32'h0001_0006, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b1, 12'h003, 2'b11, 16'h0000, 1'b0};
        vecs[2]  = '{32'h0001_0007, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5600, 1'b0, 1'b1, 12'h003, 2'b10, 16'h0000, 1'b0};
        vecs[3]  = '{32'h0001_0008, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0078, 1'b0, 1'b1, 12'h004, 2'b01, 16'h0000, 1'b0};
        vecs[4]  = '{32'h0002_0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 12'h000, 2'b00, 16'h0000, 1'b0};
        vecs[5]  = '{32'h0002_0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 12'h000, 2'b00, 16'h0000, 1'b0};
        vecs[6]  = '{32'h0001_1FFE, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 12'hFFF, 2'b00, 16'hAFFF, 1'b1};
        vecs[7]  = '{32'h0001_2000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 12'h000, 2'b00, 16'h0000, 1'b0};
        vecs[8]  = '{32'h0001_000B, 1'b1, 1'b1, 1'b0, 1'b1, 16'h4242, 1'b0, 1'b0, 12'h005, 2'b00, 16'h0000, 1'b0};
        vecs[9]  = '{32'h0001_0004, 1'b0, 1'b0, 1'b1, 1'b1, 16'h7777, 1'b1, 1'b0, 12'h002, 2'b00, 16'hBEEF, 1'b1};
        vecs[10] = '{32'h0000_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 12'h000, 2'b00, 16'h0000, 1'b0};

        bus_idle();
        reset = 1'b1;
`ifdef EXT_SRAM_TARGET_WPROT_EN
        wp = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_ad_oe",     {31'd0, bus_if.ad_oe}, 32'd0);
        check("rst_mem_re",    {31'd0, mem_re},       32'd0);
        check("rst_mem_we",    {31'd0, mem_we},       32'd0);
        check("rst_mem_be",    {30'd0, mem_be},       32'd0);
        check("rst_err_tmo",   {31'd0, err_tmo},      32'd0);
        check("rst_busy",      {31'd0, busy},         32'd0);
        check("rst_mem_addr",  {20'd0, mem_addr},     32'd0);
        check("rst_mem_wdata", {16'd0, mem_wdata},    32'd0);
`ifdef EXT_SRAM_TARGET_WPROT_EN
        check("rst_wp_viol",   {31'd0, wp_viol},      32'd0);
`endif
        reset = 1'b0;

        for (int v = 0; v < NV; v++) begin
            re0 = re_cnt;
            we0 = we_cnt;
            oe0 = oe_cyc;
            addr_phases(vecs[v].addr, vecs[v].ble_n);
            @(negedge clk);
            bus_if.ale1  = 1'b0;
            bus_if.oe    = vecs[v].rd;
            bus_if.we    = vecs[v].wr;
            bus_if.bhe_n = vecs[v].bhe_n;
            @(negedge clk);
            if (vecs[v].wr) bus_if.ad_in = vecs[v].wdata;
            @(negedge clk);
            t3_oe  = bus_if.ad_oe;
            t3_out = bus_if.ad_out;
            bus_if.we = 1'b0;
            @(negedge clk);
            bus_idle();
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_re_pulses", v),  re_cnt - re0, {31'd0, vecs[v].exp_re});
            check($sformatf("v%0d_we_pulses", v),  we_cnt - we0, {31'd0, vecs[v].exp_we});
            check($sformatf("v%0d_t3_ad_oe", v),   {31'd0, t3_oe}, {31'd0, vecs[v].exp_oe});
            check($sformatf("v%0d_t3_ad_out", v),  {16'd0, t3_out}, {16'd0, vecs[v].exp_out});
            check($sformatf("v%0d_oe_cycles", v),  oe_cyc - oe0, vecs[v].exp_oe ? 32'd3 : 32'd0);
            check($sformatf("v%0d_end_busy", v),   {31'd0, busy}, 32'd0);
            if (vecs[v].exp_re)
                check($sformatf("v%0d_re_addr", v), {20'd0, re_addr}, {20'd0, vecs[v].exp_addr});
            if (vecs[v].exp_we) begin
                check($sformatf("v%0d_we_addr", v), {20'd0, we_addr}, {20'd0, vecs[v].exp_addr});
                check($sformatf("v%0d_we_data", v), {16'd0, we_data}, {16'd0, vecs[v].wdata});
                check($sformatf("v%0d_we_be", v),   {30'd0, we_be},   {30'd0, vecs[v].exp_be});
            end
        end

        // ale0 held high: the 15th edge after entering A0 launches err_tmo.
        err0 = err_cnt;
        first_err = 0;
        busy16 = 1'b1;
        @(negedge clk);
        bus_if.ale0  = 1'b1;
        bus_if.ad_in = 16'h1111;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (err_tmo && first_err == 0) first_err = i;
            if (i == 16) busy16 = busy;
        end
        bus_if.ale0 = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus_idle();
        check("tmo_first_cycle", first_err, 32'd16);
        check("tmo_busy_after",  {31'd0, busy16}, 32'd0);
        check("tmo_pulse_count", err_cnt - err0, 32'd1);
        check("tmo_busy_reset",  {31'd0, busy}, 32'd0);

        // Reset in the middle of a read drops ad_oe at that edge.
        addr_phases(32'h0001_0004, 1'b0);
        @(negedge clk);
        bus_if.ale1 = 1'b0;
        bus_if.oe   = 1'b1;
        @(negedge clk);
        check("rdrst_ad_oe_before", {31'd0, bus_if.ad_oe}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rdrst_ad_oe_after", {31'd0, bus_if.ad_oe}, 32'd0);
        check("rdrst_busy_after",  {31'd0, busy}, 32'd0);
        reset = 1'b0;
        bus_idle();
        repeat (2) @(negedge clk);

        // ale0 during RD is honoured only after oe drops; the next read follows.
        re0 = re_cnt;
        addr_phases(32'h0001_0004, 1'b0);
        @(negedge clk);
        bus_if.ale1 = 1'b0;
        bus_if.oe   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("b2b_first_data", {16'd0, bus_if.ad_out}, 32'h0000_BEEF);
        bus_if.ale0  = 1'b1;
        bus_if.ad_in = 16'h8005;
        @(negedge clk);
        check("b2b_still_driving", {31'd0, bus_if.ad_oe}, 32'd1);
        bus_if.oe = 1'b0;
        @(negedge clk);
        check("b2b_busy_in_a0", {31'd0, busy}, 32'd1);
        check("b2b_oe_released", {31'd0, bus_if.ad_oe}, 32'd0);
        bus_if.ale0 = 1'b0;
        @(negedge clk);
        bus_if.ale1  = 1'b1;
        bus_if.ad_in = 16'h0000;
        @(negedge clk);
        bus_if.ale1 = 1'b0;
        bus_if.oe   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("b2b_second_data", {16'd0, bus_if.ad_out}, 32'h0000_A005);
        bus_if.oe = 1'b0;
        @(negedge clk);
        bus_idle();
        repeat (2) @(negedge clk);
        check("b2b_re_pulses", re_cnt - re0, 32'd2);
        check("b2b_re_addr",   {20'd0, re_addr}, 32'd5);
        check("b2b_end_busy",  {31'd0, busy}, 32'd0);

`ifdef EXT_SRAM_TARGET_WPROT_EN
        begin
            int wpv0;
            we0  = we_cnt;
            wpv0 = wpv_cnt;
            wp   = 1'b1;
            addr_phases(32'h0001_0000, 1'b0);
            @(negedge clk);
            bus_if.ale1  = 1'b0;
            bus_if.we    = 1'b1;
            bus_if.bhe_n = 1'b0;
            @(negedge clk);
            bus_if.ad_in = 16'h9999;
            @(negedge clk);
            bus_if.we = 1'b0;
            @(negedge clk);
            bus_idle();
            repeat (2) @(negedge clk);
            wp = 1'b0;
            check("wp_we_pulses",   we_cnt - we0,    32'd0);
            check("wp_viol_pulses", wpv_cnt - wpv0,  32'd1);
            check("wp_end_busy",    {31'd0, busy},   32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
